// File: rtl/wavegen_pkg.sv
// Shared types and helpers for the multi-channel waveform generator.
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_TRI  = 2'd0,
    MODE_SAW  = 2'd1,
    MODE_SQR  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Evenly spread start phase: idx * 2^width / channels, truncated.
  function automatic longint unsigned reset_phase(int unsigned idx, int unsigned channels,
                                                  int unsigned width);
    return (64'(idx) << width) / 64'(channels);
  endfunction

endpackage

// File: rtl/wavegen_channel.sv
// One waveform channel: amplitude counter, direction bit, step arithmetic and output mapping.
module wavegen_channel
  import wavegen_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               STEP_W = 4,
  parameter logic [WIDTH-1:0] INIT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  mode_e             mode,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  sample,
  output logic              period_q
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             dir, dir_nxt;
  logic             period_nxt;
  logic [WIDTH:0]   step_ext, sum;

  // One extra bit so the up-count never overflows before the clamp test.
  assign step_ext = (WIDTH+1)'(step);
  assign sum      = {1'b0, cnt} + step_ext;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    cnt_nxt    = cnt;
    dir_nxt    = dir;
    period_nxt = 1'b0;
    if (mode == MODE_SAW || mode == MODE_SQR) begin
      dir_nxt = 1'b1;
      if (step_ext != '0) begin
        cnt_nxt    = sum[WIDTH-1:0];
        period_nxt = sum[WIDTH];
      end
    end else if (step_ext != '0) begin
      if (dir) begin
        if (sum >= {1'b0, MAX}) begin
          cnt_nxt = MAX;
          dir_nxt = 1'b0;
        end else begin
          cnt_nxt = sum[WIDTH-1:0];
        end
      end else if ({1'b0, cnt} <= step_ext) begin
        cnt_nxt    = '0;
        dir_nxt    = 1'b1;
        period_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt - step_ext[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      cnt      <= INIT;
      dir      <= 1'b1;
      period_q <= 1'b0;
    end else if (load) begin
      cnt      <= load_val;
      dir      <= 1'b1;
      period_q <= 1'b0;
    end else if (advance) begin
      cnt      <= cnt_nxt;
      dir      <= dir_nxt;
      period_q <= period_nxt;
    end else begin
      period_q <= 1'b0;
    end
  end

  always_comb begin
    sample = cnt;
    if (mode == MODE_SQR) sample = cnt[WIDTH-1] ? MAX : '0;
  end

endmodule

// File: rtl/multi_wave_gen.sv
// Multi-channel triangle/sawtooth/square DAC generator with channel-0 period sync.
// Optional amplitude scaling stage enabled by defining WAVEGEN_AMPL_EN.
module multi_wave_gen
  import wavegen_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int STEP_W   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                mode,
  input  logic [STEP_W-1:0]         step,
  input  logic                      phase_load,
  input  logic [CHANNELS*WIDTH-1:0] phase_val,
`ifdef WAVEGEN_AMPL_EN
  input  logic [WIDTH-1:0]          ampl,
`endif
  output logic [CHANNELS*WIDTH-1:0] dac_out,
  output logic                      sync
);

  mode_e                     mode_sel;
  logic                      advance;
  logic [CHANNELS*WIDTH-1:0] samples;
  logic [CHANNELS-1:0]       period;
  logic                      sync_q;
  logic                      unused_period;

  assign mode_sel = mode_e'(mode);
  // A phase load wins over enable and suppresses the advance for that cycle.
  assign advance  = enable & ~phase_load;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    wavegen_channel #(
      .WIDTH (WIDTH),
      .STEP_W(STEP_W),
      .INIT  (WIDTH'(reset_phase(i, CHANNELS, WIDTH)))
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .load    (phase_load),
      .advance (advance),
      .mode    (mode_sel),
      .step    (step),
      .load_val(phase_val[i*WIDTH +: WIDTH]),
      .sample  (samples[i*WIDTH +: WIDTH]),
      .period_q(period[i])
    );
  end

  // Only channel 0 drives sync; the other period flags are intentionally dropped.
  assign unused_period = ^period;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     sync_q <= 1'b0;
    else if (phase_load || !enable) sync_q <= 1'b0;
    else                            sync_q <= period[0];
  end

`ifdef WAVEGEN_AMPL_EN
  logic sync_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_amp
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   amp_q;

    assign prod = (2*WIDTH)'(samples[i*WIDTH +: WIDTH]) * (2*WIDTH)'(ampl);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) amp_q <= '0;
      else        amp_q <= WIDTH'(prod >> WIDTH);
    end

    assign dac_out[i*WIDTH +: WIDTH] = amp_q;
  end

  // Extra stage keeps sync aligned with the registered scaled samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_d <= 1'b0;
    else        sync_d <= sync_q;
  end

  assign sync = sync_d;
`else
  assign dac_out = samples;
  assign sync    = sync_q;
`endif

endmodule

// File: tb/tb_multi_wave_gen.sv
// Directed, table-driven bench for multi_wave_gen (default build, 8-bit step input).
module tb_multi_wave_gen;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int STEP_W   = 8;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enable;
  logic [1:0]                mode;
  logic [STEP_W-1:0]         step;
  logic                      phase_load;
  logic [CHANNELS*WIDTH-1:0] phase_val;
  logic [CHANNELS*WIDTH-1:0] dac_out;
  logic                      sync;
`ifdef WAVEGEN_AMPL_EN
  logic [WIDTH-1:0]          ampl = '1;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multi_wave_gen #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .STEP_W  (STEP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .step      (step),
    .phase_load(phase_load),
    .phase_val (phase_val),
`ifdef WAVEGEN_AMPL_EN
    .ampl      (ampl),
`endif
    .dac_out   (dac_out),
    .sync      (sync)
  );

  typedef struct {
    logic       ld;
    logic       en;
    logic [1:0] md;
    logic [7:0] st;
    logic [7:0] p1;
    logic [7:0] p0;
    logic [7:0] e0;
    logic [7:0] e1;
    logic       es;
  } vec_t;

  vec_t vecs[38];

  function automatic vec_t v(logic ld, logic en, logic [1:0] md, logic [7:0] st,
                             logic [7:0] p1, logic [7:0] p0,
                             logic [7:0] e0, logic [7:0] e1, logic es);
    vec_t r;
    r.ld = ld; r.en = en; r.md = md; r.st = st;
    r.p1 = p1; r.p0 = p0; r.e0 = e0; r.e1 = e1; r.es = es;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sync_early;

  initial begin
    // Rows: load, en, mode, step, pval ch1, pval ch0 -> ch0, ch1, sync after the edge.
    vecs[0]  = v(1, 1, 0, 100,  50,   0,   0,  50, 0);
    vecs[1]  = v(0, 1, 0, 100,   0,   0, 100, 150, 0);
    vecs[2]  = v(0, 1, 0, 100,   0,   0, 200, 250, 0);
    vecs[3]  = v(0, 1, 0, 100,   0,   0, 255, 255, 0);
    vecs[4]  = v(0, 1, 0, 100,   0,   0, 155, 155, 0);
    vecs[5]  = v(0, 1, 0, 100,   0,   0,  55,  55, 0);
    vecs[6]  = v(0, 1, 0, 100,   0,   0,   0,   0, 0);
    vecs[7]  = v(0, 1, 0, 100,   0,   0, 100, 100, 1);
    vecs[8]  = v(0, 1, 0, 100,   0,   0, 200, 200, 0);
    vecs[9]  = v(1, 1, 1, 100, 128,   0,   0, 128, 0);
    vecs[10] = v(0, 1, 1, 100,   0,   0, 100, 228, 0);
    vecs[11] = v(0, 1, 1, 100,   0,   0, 200,  72, 0);
    vecs[12] = v(0, 1, 1, 100,   0,   0,  44, 172, 0);
    vecs[13] = v(0, 1, 1, 100,   0,   0, 144,  16, 1);
    vecs[14] = v(0, 1, 1, 100,   0,   0, 244, 116, 0);
    vecs[15] = v(0, 1, 1, 100,   0,   0,  88, 216, 0);
    vecs[16] = v(0, 1, 1, 100,   0,   0, 188,  60, 1);
    vecs[17] = v(1, 1, 2,  64, 128,   0,   0, 255, 0);
    vecs[18] = v(0, 1, 2,  64,   0,   0,   0, 255, 0);
    vecs[19] = v(0, 1, 2,  64,   0,   0, 255,   0, 0);
    vecs[20] = v(0, 1, 2,  64,   0,   0, 255,   0, 0);
    vecs[21] = v(0, 1, 2,  64,   0,   0,   0, 255, 0);
    vecs[22] = v(0, 1, 2,  64,   0,   0,   0, 255, 1);
    vecs[23] = v(0, 1, 2,   0,   0,   0,   0, 255, 0);
    vecs[24] = v(0, 1, 1,   0,   0,   0,  64, 192, 0);
    vecs[25] = v(0, 1, 0, 100,   0,   0, 164, 255, 0);
    vecs[26] = v(0, 1, 0, 100,   0,   0, 255, 155, 0);
    vecs[27] = v(0, 1, 1,  10,   0,   0,   9, 165, 0);
    vecs[28] = v(0, 1, 0,  10,   0,   0,  19, 175, 1);
    vecs[29] = v(1, 1, 0,  10,  10, 200, 200,  10, 0);
    vecs[30] = v(0, 0, 0,  10,   0,   0, 200,  10, 0);
    vecs[31] = v(0, 0, 0,  10,   0,   0, 200,  10, 0);
    vecs[32] = v(0, 0, 0,  10,   0,   0, 200,  10, 0);
    vecs[33] = v(0, 0, 0,  10,   0,   0, 200,  10, 0);
    vecs[34] = v(0, 0, 0,  10,   0,   0, 200,  10, 0);
    vecs[35] = v(0, 1, 0,  10,   0,   0, 210,  20, 0);
    vecs[36] = v(0, 1, 3,  50,   0,   0, 255,  70, 0);
    vecs[37] = v(0, 1, 3,  50,   0,   0, 205, 120, 0);

    reset      = 1'b0;
    enable     = 1'b1;
    mode       = 2'd0;
    step       = 8'd1;
    phase_load = 1'b0;
    phase_val  = '0;

    #12;
    check("reset_ch0", 32'(dac_out[7:0]), 32'd0);
    check("reset_ch1", 32'(dac_out[15:8]), 32'd128);
    check("reset_sync", 32'(sync), 32'd0);

    // Long step-1 triangle: peak at 255, back to 0 at cycle 510, sync in cycle 511.
    @(negedge clk);
    reset = 1'b1;
    check("tri1_c0_ch1", 32'(dac_out[15:8]), 32'd128);
    sync_early = 0;
    for (int k = 1; k <= 511; k++) begin
      tick();
      if (k < 511 && sync === 1'b1) sync_early++;
      if (k == 1) begin
        check("tri1_c1_ch0", 32'(dac_out[7:0]), 32'd1);
        check("tri1_c1_ch1", 32'(dac_out[15:8]), 32'd129);
      end
      if (k == 255) check("tri1_c255", 32'(dac_out[7:0]), 32'd255);
      if (k == 256) check("tri1_c256", 32'(dac_out[7:0]), 32'd254);
      if (k == 510) check("tri1_c510", 32'(dac_out[7:0]), 32'd0);
      if (k == 511) check("tri1_sync511", 32'(sync), 32'd1);
    end
    check("tri1_no_early_sync", 32'(sync_early), 32'd0);

    for (int i = 0; i < 38; i++) begin
      phase_load = vecs[i].ld;
      enable     = vecs[i].en;
      mode       = vecs[i].md;
      step       = vecs[i].st;
      phase_val  = {vecs[i].p1, vecs[i].p0};
      tick();
      check($sformatf("vec%0d_ch0", i), 32'(dac_out[7:0]), 32'(vecs[i].e0));
      check($sformatf("vec%0d_ch1", i), 32'(dac_out[15:8]), 32'(vecs[i].e1));
      check($sformatf("vec%0d_sync", i), 32'(sync), 32'(vecs[i].es));
    end

    // Asynchronous reset while ch0 = 77 and counting down.
    phase_load = 1'b1;
    enable     = 1'b1;
    mode       = 2'd0;
    step       = 8'd55;
    phase_val  = {8'd0, 8'd200};
    tick();
    phase_load = 1'b0;
    tick();
    check("pre_rst_peak", 32'(dac_out[7:0]), 32'd255);
    step = 8'd178;
    tick();
    check("pre_rst_77", 32'(dac_out[7:0]), 32'd77);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_ch0", 32'(dac_out[7:0]), 32'd0);
    check("async_rst_ch1", 32'(dac_out[15:8]), 32'd128);
    check("async_rst_sync", 32'(sync), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step  = 8'd15;
    tick();
    check("post_rst_ch0", 32'(dac_out[7:0]), 32'd15);
    check("post_rst_ch1", 32'(dac_out[15:8]), 32'd143);
    check("post_rst_sync", 32'(sync), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
